fetch_queue: RTL and testbench

- Parametrised instruction queue between the fetch2 and decode stages. It decouples fetch from decode.
- Accepts up to FETCH_W instructions per cycle from fetch2 and delivers up to ISSUE_W per cycle to decode.
- Truncates a fetch group after a predicted-taken or excepting lane.
- Replaces the fixed one-instruction fetch2->decode pass register. Flushed on branch mispredict or exception redirect.

---
 rtl/fetch_queue.sv | 144 ++++++++++++++
 tb/tb_fetch_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch2 and decode; truncates groups after taken/excepting lanes.
// Optional statistics counters are enabled with the FETCH_QUEUE_STAT_EN macro.
module fetch_queue #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 1,
  parameter int DEPTH   = 8,
  parameter int ECODE_W = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FETCH_W-1:0]           in_mask,
  input  logic [FETCH_W*32-1:0]        in_pc,
  input  logic [FETCH_W*32-1:0]        in_inst,
  input  logic [FETCH_W-1:0]           in_pred_taken,
  input  logic [FETCH_W-1:0]           in_excp,
  input  logic [FETCH_W*ECODE_W-1:0]   in_ecode,
  output logic [ISSUE_W-1:0]           out_valid,
  input  logic                         out_ready,
  output logic [ISSUE_W*32-1:0]        out_pc,
  output logic [ISSUE_W*32-1:0]        out_inst,
  output logic [ISSUE_W-1:0]           out_pred_taken,
  output logic [ISSUE_W-1:0]           out_excp,
  output logic [ISSUE_W*ECODE_W-1:0]   out_ecode,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  stat_full_cycles,
  output logic [31:0]                  stat_empty_cycles,
  output logic [31:0]                  stat_flushes
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [31:0]        pc_mem   [DEPTH];
  logic [31:0]        inst_mem [DEPTH];
  logic               pt_mem   [DEPTH];
  logic               ex_mem   [DEPTH];
  logic [ECODE_W-1:0] ec_mem   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [FETCH_W-1:0] accept;
  logic [CNT_W-1:0] push_n, pop_n;
  logic             grp_open, do_push, do_pop;

  assign in_ready = (count_q <= CNT_W'(DEPTH - FETCH_W));
  assign do_push  = in_valid && in_ready && !flush;
  assign do_pop   = out_ready && !flush;
  assign pop_n    = (count_q < CNT_W'(ISSUE_W)) ? count_q : CNT_W'(ISSUE_W);
  assign count    = count_q;

  // Lane acceptance: contiguous mask prefix, closing after the first taken or excepting lane
  always_comb begin
    accept   = '0;
    push_n   = '0;
    grp_open = 1'b1;
    for (int i = 0; i < FETCH_W; i++) begin
      accept[i] = grp_open && in_mask[i];
      push_n    = push_n + (accept[i] ? CNT_W'(1) : CNT_W'(0));
      grp_open  = accept[i] && !(in_pred_taken[i] || in_excp[i]);
    end
  end

  always_comb begin
    head_d  = flush ? '0 : (do_pop  ? head_q + PTR_W'(pop_n)  : head_q);
    tail_d  = flush ? '0 : (do_push ? tail_q + PTR_W'(push_n) : tail_q);
    count_d = flush ? '0 : (count_q + (do_push ? push_n : CNT_W'(0)) - (do_pop ? pop_n : CNT_W'(0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (do_push && accept[i]) begin
        pc_mem[tail_q + PTR_W'(i)]   <= in_pc[i*32 +: 32];
        inst_mem[tail_q + PTR_W'(i)] <= in_inst[i*32 +: 32];
        pt_mem[tail_q + PTR_W'(i)]   <= in_pred_taken[i];
        ex_mem[tail_q + PTR_W'(i)]   <= in_excp[i];
        ec_mem[tail_q + PTR_W'(i)]   <= in_ecode[i*ECODE_W +: ECODE_W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      out_valid[i]                   = count_q > CNT_W'(i);
      out_pc[i*32 +: 32]             = pc_mem[head_q + PTR_W'(i)];
      out_inst[i*32 +: 32]           = inst_mem[head_q + PTR_W'(i)];
      out_pred_taken[i]              = pt_mem[head_q + PTR_W'(i)];
      out_excp[i]                    = ex_mem[head_q + PTR_W'(i)];
      out_ecode[i*ECODE_W +: ECODE_W] = ec_mem[head_q + PTR_W'(i)];
    end
  end

`ifdef FETCH_QUEUE_STAT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] stat_full_q, stat_full_d;
  logic [31:0] stat_empty_q, stat_empty_d;
  logic [31:0] stat_flush_q, stat_flush_d;

  always_comb begin
    stat_full_d  = sat_inc(stat_full_q, in_valid && !in_ready && !flush);
    stat_empty_d = sat_inc(stat_empty_q, count_q == '0);
    stat_flush_d = sat_inc(stat_flush_q, flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_full_q  <= 32'd0;
      stat_empty_q <= 32'd0;
      stat_flush_q <= 32'd0;
    end else begin
      stat_full_q  <= stat_full_d;
      stat_empty_q <= stat_empty_d;
      stat_flush_q <= stat_flush_d;
    end
  end

  assign stat_full_cycles  = stat_full_q;
  assign stat_empty_cycles = stat_empty_q;
  assign stat_flushes      = stat_flush_q;
`else
  assign stat_full_cycles  = 32'd0;
  assign stat_empty_cycles = 32'd0;
  assign stat_flushes      = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus for fetch_queue, checked against a queue-based reference model.
module tb_fetch_queue;
  localparam int FW = 2;
  localparam int IW = 1;
  localparam int D  = 8;
  localparam int EW = 6;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic            in_ready;
  logic [FW-1:0]   in_mask, in_pred_taken, in_excp;
  logic [FW*32-1:0] in_pc, in_inst;
  logic [FW*EW-1:0] in_ecode;
  logic [IW-1:0]   out_valid, out_pred_taken, out_excp;
  logic [IW*32-1:0] out_pc, out_inst;
  logic [IW*EW-1:0] out_ecode;
  logic [3:0]      count;
  logic [31:0]     stat_full_cycles, stat_empty_cycles, stat_flushes;

  fetch_queue #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(D), .ECODE_W(EW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .in_pc(in_pc), .in_inst(in_inst), .in_pred_taken(in_pred_taken),
    .in_excp(in_excp), .in_ecode(in_ecode), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_pred_taken(out_pred_taken),
    .out_excp(out_excp), .out_ecode(out_ecode), .count(count),
    .stat_full_cycles(stat_full_cycles), .stat_empty_cycles(stat_empty_cycles),
    .stat_flushes(stat_flushes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic          pt;
    logic          ex;
    logic [EW-1:0] ec;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_full, m_empty, m_fl;
  int          passed = 0;
  int          total  = 0;
  logic [31:0] next_pc = 32'h0;
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic compare();
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'((D - mq.size()) >= FW));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_inst", out_inst, mq[0].inst);
      chk("out_pt", 32'(out_pred_taken), 32'(mq[0].pt));
      chk("out_excp", 32'(out_excp), 32'(mq[0].ex));
      chk("out_ecode", 32'(out_ecode), 32'(mq[0].ec));
    end
`ifdef FETCH_QUEUE_STAT_EN
    chk("stat_full", stat_full_cycles, m_full);
    chk("stat_empty", stat_empty_cycles, m_empty);
    chk("stat_flush", stat_flushes, m_fl);
`else
    chk("stat_full", stat_full_cycles, 32'd0);
    chk("stat_empty", stat_empty_cycles, 32'd0);
    chk("stat_flush", stat_flushes, 32'd0);
`endif
  endtask

  // One clock: apply the queue rules to the model using the inputs held across the edge
  task automatic cycle();
    int   cnt;
    int   acc;
    bit   rdy;
    ent_t e;
    @(posedge clk);
    cnt = mq.size();
    rdy = (D - cnt) >= FW;
    acc = 0;
    if (rst) begin
      mq.delete();
      m_full = 0; m_empty = 0; m_fl = 0;
    end else begin
      if (flush) m_fl++;
      if (in_valid && !rdy && !flush) m_full++;
      if (cnt == 0) m_empty++;
      if (flush) mq.delete();
      else begin
        if (out_ready && cnt > 0) e = mq.pop_front();
        if (in_valid && rdy) begin
          for (int i = 0; i < FW; i++) begin
            if (!in_mask[i]) break;
            e.pc = in_pc[i*32 +: 32]; e.inst = in_inst[i*32 +: 32];
            e.pt = in_pred_taken[i]; e.ex = in_excp[i]; e.ec = in_ecode[i*EW +: EW];
            mq.push_back(e);
            acc++;
            if (in_pred_taken[i] || in_excp[i]) break;
          end
        end
      end
    end
    next_pc = next_pc + 32'(4 * acc);
    #1;
    compare();
  endtask

  task automatic drive(input bit v, input logic [1:0] m, input logic [1:0] pt,
                       input logic [1:0] ex, input logic [EW-1:0] ec0);
    in_valid = v; in_mask = m; in_pred_taken = pt; in_excp = ex;
    in_pc    = {next_pc + 32'd4, next_pc};
    in_inst  = {$urandom(), $urandom()};
    in_ecode = {EW'($urandom()), ec0};
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 2'b00, 6'h00);
    m_full = 0; m_empty = 0; m_fl = 0;
    #1;
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_stat_full", stat_full_cycles, 32'd0);

    // Fill to full, then drain in order
    next_pc = 32'h1C00_0000;
    for (int g = 0; g < 3; g++) begin drive(1'b1, 2'b11, 2'b00, 2'b00, 6'h00); cycle(); end
    chk("fill3_count", 32'(count), 32'd6);
    chk("fill3_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 2'b11, 2'b00, 2'b00, 6'h00); cycle();
    chk("fill4_count", 32'(count), 32'd8);
    chk("fill4_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 6'h00);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_pc", out_pc, 32'h1C00_0000 + 32'(4 * k));
      cycle();
    end
    chk("drain_count", 32'(count), 32'd0);

    // Truncation after taken and excepting lanes
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 2'b01, 2'b00, 6'h00); cycle();
    chk("trunc_taken_count", 32'(count), 32'd1);
    drive(1'b1, 2'b11, 2'b00, 2'b01, 6'h08); cycle();
    chk("trunc_excp_count", 32'(count), 32'd2);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 6'h00);
    out_ready = 1'b1; cycle();
    chk("trunc_excp_flag", 32'(out_excp), 32'd1);
    chk("trunc_ecode", 32'(out_ecode), 32'h08);
    cycle();
    chk("trunc_empty", 32'(count), 32'd0);

    // Wrap with simultaneous push/pop and a decode stall every third cycle
    exp_pc = next_pc;
    for (int c = 0; c < 80; c++) begin
      drive(mq.size() < 5, 2'b11, 2'b00, 2'b00, 6'h00);
      out_ready = (c % 3) != 2;
      if (out_ready && mq.size() > 0) begin
        chk("wrap_seq", out_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      cycle();
    end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 6'h00);
    out_ready = 1'b1;
    while (mq.size() > 0) cycle();

    // Flush colliding with push and pop
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin drive(1'b1, 2'b11, 2'b00, 2'b00, 6'h00); cycle(); end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 6'h00);
    out_ready = 1'b1; cycle();
    chk("pre_flush_count", 32'(count), 32'd5);
    drive(1'b1, 2'b11, 2'b00, 2'b00, 6'h00);
    in_pc = {32'hBAD0_0004, 32'hBAD0_0000};
    flush = 1'b1; cycle();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 6'h00); cycle();
    drive(1'b1, 2'b01, 2'b00, 2'b00, 6'h00); cycle();
    chk("post_flush_pc", out_pc, next_pc - 32'd4);

    // Statistics: three full-stall cycles and one flush
    rst = 1'b1; drive(1'b0, 2'b00, 2'b00, 2'b00, 6'h00); out_ready = 1'b0; cycle();
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin drive(1'b1, 2'b11, 2'b00, 2'b00, 6'h00); cycle(); end
    for (int g = 0; g < 3; g++) begin drive(1'b1, 2'b11, 2'b00, 2'b00, 6'h00); cycle(); end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 6'h00);
    flush = 1'b1; cycle();
    flush = 1'b0;
`ifdef FETCH_QUEUE_STAT_EN
    chk("stats_full3", stat_full_cycles, 32'd3);
    chk("stats_flush1", stat_flushes, 32'd1);
`else
    chk("stats_full_off", stat_full_cycles, 32'd0);
    chk("stats_flush_off", stat_flushes, 32'd0);
`endif

    // Random traffic with occasional flush and one mid-run reset
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom()),
            ($urandom_range(0, 5) == 0) ? 2'($urandom()) : 2'b00,
            ($urandom_range(0, 7) == 0) ? 2'($urandom()) : 2'b00,
            EW'($urandom()));
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 24) == 0;
      rst       = (c == 200);
      cycle();
    end
    rst = 1'b0; flush = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
